mul_hilo_ctrl: RTL
==================

// Module: mul_hilo_ctrl
// PURPOSE
// - Multi-cycle sequencer and HI/LO result register pair sitting directly downstream of the combinational Booth multiplier.
// - Latches operands and drives them to the multiplier, then waits LATENCY cycles for the array to settle (multicycle path).
// - Captures the 64-bit product into HI/LO and exposes them to the datapath (mfhi/mflo).
// - Uses a start/busy/done handshake with the control unit.
// PARAMETERS
// - DW       32  operand width; HI and LO are each DW bits wide.
// - LATENCY  2   WAIT-state cycles before capture; legal range >= 1 (LATENCY=0 is an elaboration error).
// PORTS
// - clk      in   1   single clock; all state updates on rising edge.
// - clear    in   1   reset; synchronous, active-high.
// - start    in   1   request a multiply; sampled only in IDLE.
// - M_in     in   DW  multiplicand (signed), sampled with start.
// - Q_in     in   DW  multiplier (signed), sampled with start.
// - mul_M    out  DW  registered multiplicand, drives the multiplier M.
// - mul_Q    out  DW  registered multiplier, drives the multiplier Q.
// - mul_hi   in   DW  multiplier res_hi.
// - mul_lo   in   DW  multiplier res_lo.
// - busy     out  1   high while state == WAIT.
// - done     out  1   one-cycle pulse; HI/LO hold the new product.
// - hi_out   out  DW  HI register.
// - lo_out   out  DW  LO register.
// - mthi     in   1   write mt_data to HI (HILO_MOVE_EN only).
// - mtlo     in   1   write mt_data to LO (HILO_MOVE_EN only).
// - mt_data  in   DW  move-to data (HILO_MOVE_EN only).
// BEHAVIOUR
// - Reset (clear=1 at an edge): state=IDLE, cnt=0, mul_M=mul_Q=0, HI=LO=0, busy=0, done=0.
//   Reset overrides every other input.
// - Reset mid-operation aborts the multiply; HI/LO are zeroed and the product is never written.
// - FSM states: IDLE, WAIT. busy is decoded from state; done is a register.
// - IDLE with start=1: mul_M<=M_in, mul_Q<=Q_in, cnt<=LATENCY-1, state<=WAIT.
// - IDLE with start=0: hold state; done<=0.
// - WAIT with cnt!=0: cnt<=cnt-1.
// - WAIT with cnt==0: HI<=mul_hi, LO<=mul_lo, done<=1, state<=IDLE.
// - Timing: start sampled at edge E0 -> HI/LO updated at edge E(LATENCY); done high for the cycle after that edge.
//   busy is high from E0 until E(LATENCY).
// - done clears at the next edge unconditionally; it is never held.
// - start while busy is ignored. It is not queued and the operands are not resampled.
// - start in the done cycle (state already IDLE) is accepted: back-to-back multiplies, one per LATENCY+1 cycles.
// - mul_M/mul_Q hold stable from E0 through the capture edge and keep their value in IDLE.
// - Arithmetic: signed two's complement; the 64-bit product is {HI,LO}. No overflow flag; the full product always fits.
// - cnt width: $clog2(LATENCY)+1 bits; cnt never wraps below 0.
// CONFIGURATION
// - HILO_MOVE_EN defined: the mthi/mtlo/mt_data ports exist.
//   - In IDLE: mthi=1 -> HI<=mt_data; mtlo=1 -> LO<=mt_data; both may assert in the same cycle.
//   - mthi/mtlo together with start in IDLE: both writes take effect; the later capture overwrites them.
//   - mthi/mtlo while busy, or on the capture edge, are ignored. The capture wins and no write is deferred.
//   - done is not pulsed by move-to writes.
// - HILO_MOVE_EN undefined: the ports are absent and HI/LO are written only by reset and multiply capture.
// TESTING
// - Reset: clear=1 for 2 cycles with random inputs -> hi_out=lo_out=0, busy=0, done=0, mul_M=mul_Q=0.
// - LATENCY=2, M_in=7, Q_in=32'hFFFFFFFD (-3), start 1 cycle ->
//   busy high 2 cycles, done pulses 1 cycle, HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
// - M=Q=32'h80000000 -> HI=32'h40000000, LO=0.
//   Then M=Q=32'hFFFFFFFF started in the done cycle -> accepted, HI=0, LO=1.
// - start pulsed at E0+1 with M=5, Q=5 during the busy of M=3, Q=4 -> ignored;
//   HI=0, LO=12, mul_M=3 throughout, a single done pulse.
// - clear asserted 1 cycle after start of M=9, Q=9 -> HI=LO=0, done never pulses, busy=0 after the clear edge.
// - HILO_MOVE_EN: mthi with mt_data=32'hDEADBEEF in IDLE -> HI=32'hDEADBEEF next cycle;
//   mtlo while busy -> LO unchanged until the product capture.

Source files
------------

// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - multi-cycle multiply sequencer with HI/LO result registers (optional HILO_MOVE_EN)
module mul_hilo_ctrl #(
   parameter int DW      = 32,
   parameter int LATENCY = 2
) (
   input  logic          clk,
   input  logic          clear,
   input  logic          start,
   input  logic [DW-1:0] M_in,
   input  logic [DW-1:0] Q_in,
   output logic [DW-1:0] mul_M,
   output logic [DW-1:0] mul_Q,
   input  logic [DW-1:0] mul_hi,
   input  logic [DW-1:0] mul_lo,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] hi_out,
`ifdef HILO_MOVE_EN
   output logic [DW-1:0] lo_out,
   input  logic          mthi,
   input  logic          mtlo,
   input  logic [DW-1:0] mt_data
`else
   output logic [DW-1:0] lo_out
`endif
);

   localparam int CW = $clog2(LATENCY) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   // A zero-cycle settle window would capture the product before the array has seen the operands.
   generate
      if (LATENCY < 1) begin : g_bad_latency
         $error("mul_hilo_ctrl: LATENCY must be >= 1");
      end
   endgenerate

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   assign busy = (state == S_WAIT);

   // Sequencer: latch operands on start, count down the settle window, then capture HI/LO.
   always_ff @(posedge clk) begin
      if (clear) begin
         state  <= S_IDLE;
         cnt    <= '0;
         mul_M  <= '0;
         mul_Q  <= '0;
         hi_out <= '0;
         lo_out <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
`ifdef HILO_MOVE_EN
               if (mthi) hi_out <= mt_data;
               if (mtlo) lo_out <= mt_data;
`endif
               if (start) begin
                  mul_M <= M_in;
                  mul_Q <= Q_in;
                  cnt   <= CNT_INIT;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  hi_out <= mul_hi;
                  lo_out <= mul_lo;
                  done   <= 1'b1;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
